parity_arb: RTL and testbench

Shared-access controller for the team's 4-bit even-parity unit (`parity_gc`). It arbitrates between a transmit-side generate requester and a receive-side check requester, drives the single `parity_gc` instance in the matching mode, and registers each result behind a valid/ready output stage. It also keeps a saturating error counter and a sticky error flag for status readout.

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_gc.sv | 20 ++
 rtl/parity_arb.sv | 146 ++++++++++++++
 tb/tb_parity_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity unit and its access controller.
//   SRC_*  : encoding of the result source (which requester was served)
//   MODE_* : operating mode of parity_gc
//   DATA_W : nibble width handled by the parity unit
package parity_pkg;

    localparam int DATA_W = 4;

    localparam logic SRC_GEN = 1'b0;
    localparam logic SRC_CHK = 1'b1;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_gc.sv
// 4-bit even-parity generate/check unit.
//   d     : data nibble
//   mode  : MODE_GEN computes a parity bit, MODE_CHK compares against p_in
//   p_in  : received parity bit (used in check mode only)
//   p_bit : even parity bit of d
//   error : check mode parity mismatch; always 0 in generate mode
module parity_gc
    import parity_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic              mode,
    input  logic              p_in,
    output logic              p_bit,
    output logic              error
);

    assign p_bit = ^d;
    assign error = (mode == MODE_CHK) ? (p_bit ^ p_in) : 1'b0;

endmodule

// File: rtl/parity_arb.sv
// Arbitrated front end for the shared parity_gc unit.
//   gen_valid/gen_data/gen_ready         : transmit-side generate requester
//   chk_valid/chk_data/chk_par/chk_ready : receive-side check requester
//   res_valid/res_src/res_data/res_par/res_err/res_ready : registered result stage
//   clr        : synchronous clear of the status counters
//   err_cnt    : saturating count of check errors
//   err_sticky : set by any check error, held until clr
module parity_arb
    import parity_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gen_valid,
    input  logic [DATA_W-1:0] gen_data,
    output logic              gen_ready,
    input  logic              chk_valid,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              chk_par,
    output logic              chk_ready,
    output logic              res_valid,
    output logic              res_src,
    output logic [DATA_W-1:0] res_data,
    output logic              res_par,
    output logic              res_err,
    input  logic              res_ready,
    input  logic              clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic              res_valid_q, res_valid_d;
    logic              res_src_q, res_src_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_par_q, res_par_d;
    logic              res_err_q, res_err_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;

    logic              slot_free;
    logic              grant_chk;
    logic              accept;
    logic [DATA_W-1:0] gc_d;
    logic              gc_mode;
    logic              gc_pbit;
    logic              gc_err;

    // The slot frees combinationally on res_ready so a draining result and
    // a new accept can share one cycle.
    assign slot_free = !res_valid_q || res_ready;

    // On a tie the requester not served last wins; otherwise whoever is valid.
    always_comb begin
        grant_chk = chk_valid;
        if (gen_valid && chk_valid) begin
            grant_chk = (last_q == SRC_GEN);
        end
    end

    assign gen_ready = slot_free && gen_valid && !grant_chk;
    assign chk_ready = slot_free && chk_valid && grant_chk;
    assign accept    = gen_ready || chk_ready;

    assign gc_d    = grant_chk ? chk_data : gen_data;
    assign gc_mode = grant_chk ? MODE_CHK : MODE_GEN;

    parity_gc u_gc (
        .d     (gc_d),
        .mode  (gc_mode),
        .p_in  (chk_par),
        .p_bit (gc_pbit),
        .error (gc_err)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_src_d    = res_src_q;
        res_data_d   = res_data_q;
        res_par_d    = res_par_q;
        res_err_d    = res_err_q;
        last_d       = last_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;

        if (accept) begin
            res_valid_d = 1'b1;
            res_src_d   = grant_chk ? SRC_CHK : SRC_GEN;
            res_data_d  = gc_d;
            // A check result reports the received bit, not the recomputed one.
            res_par_d   = grant_chk ? chk_par : gc_pbit;
            res_err_d   = gc_err;
            last_d      = grant_chk ? SRC_CHK : SRC_GEN;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end

        // clr has priority: a coincident error event is dropped.
        if (clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (chk_ready && gc_err) begin
            err_cnt_d    = sat_inc(err_cnt_q);
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_src_q    <= SRC_GEN;
            res_data_q   <= '0;
            res_par_q    <= 1'b0;
            res_err_q    <= 1'b0;
            last_q       <= SRC_CHK;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_src_q    <= res_src_d;
            res_data_q   <= res_data_d;
            res_par_q    <= res_par_d;
            res_err_q    <= res_err_d;
            last_q       <= last_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_src    = res_src_q;
    assign res_data   = res_data_q;
    assign res_par    = res_par_q;
    assign res_err    = res_err_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_arb.sv
module tb_parity_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gen_valid, chk_valid, chk_par, res_ready, clr;
    logic [3:0] gen_data, chk_data;
    logic       gen_ready, chk_ready, res_valid, res_src, res_par, res_err, err_sticky;
    logic [3:0] res_data;
    logic [7:0] err_cnt;
    logic       gen_ready2, chk_ready2, res_valid2, res_src2, res_par2, res_err2, err_sticky2;
    logic [3:0] res_data2;
    logic [1:0] err_cnt2;

    int pass_cnt = 0;
    int total_cnt = 0;

    parity_arb #(.CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .gen_valid(gen_valid), .gen_data(gen_data), .gen_ready(gen_ready),
        .chk_valid(chk_valid), .chk_data(chk_data), .chk_par(chk_par), .chk_ready(chk_ready),
        .res_valid(res_valid), .res_src(res_src), .res_data(res_data), .res_par(res_par),
        .res_err(res_err), .res_ready(res_ready), .clr(clr),
        .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    parity_arb #(.CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .gen_valid(gen_valid), .gen_data(gen_data), .gen_ready(gen_ready2),
        .chk_valid(chk_valid), .chk_data(chk_data), .chk_par(chk_par), .chk_ready(chk_ready2),
        .res_valid(res_valid2), .res_src(res_src2), .res_data(res_data2), .res_par(res_par2),
        .res_err(res_err2), .res_ready(res_ready), .clr(clr),
        .err_cnt(err_cnt2), .err_sticky(err_sticky2)
    );

    always #5 clk = ~clk;

    // Reference model: transaction-level view of the result slot and status.
    logic       m_valid, m_src, m_par, m_err, m_last, m_sticky;
    logic [3:0] m_data;
    int         m_cnt8, m_cnt2;

    function automatic logic even_par(input logic [3:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_src = 0; m_data = 0; m_par = 0; m_err = 0;
        m_last = 1; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_ready(output logic eg, output logic ec);
        eg = 0; ec = 0;
        if (!m_valid || res_ready) begin
            if (gen_valid && chk_valid) begin
                if (m_last) eg = 1; else ec = 1;
            end else begin
                eg = gen_valid;
                ec = chk_valid;
            end
        end
    endtask

    // Advance one clock and apply the transaction rules to the model.
    task automatic tick();
        logic eg, ec, e;
        model_ready(eg, ec);
        e = ec && (even_par(chk_data) != chk_par);
        @(posedge clk);
        if (eg) begin
            m_valid = 1; m_src = 0; m_data = gen_data; m_par = even_par(gen_data); m_err = 0; m_last = 0;
        end else if (ec) begin
            m_valid = 1; m_src = 1; m_data = chk_data; m_par = chk_par; m_err = e; m_last = 1;
        end else if (res_ready) begin
            m_valid = 0;
        end
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
        end else if (e) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
            m_sticky = 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        gen_valid = 0; gen_data = 0; chk_valid = 0; chk_data = 0; chk_par = 0;
        res_ready = 1; clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (res_valid !== 1'b0 || res_src !== 1'b0 || res_data !== 4'h0 || res_par !== 1'b0 || res_err !== 1'b0)
            $display("FAIL reset_res: valid=%b src=%b data=%h par=%b err=%b, required all 0", res_valid, res_src, res_data, res_par, res_err);
        else pass_cnt++;
        total_cnt++; if (err_cnt !== 8'd0 || err_sticky !== 1'b0 || gen_ready !== 1'b0 || chk_ready !== 1'b0)
            $display("FAIL reset_status: cnt=%0d sticky=%b gr=%b cr=%b, required 0", err_cnt, err_sticky, gen_ready, chk_ready);
        else pass_cnt++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_gen();
        idle_inputs();
        gen_valid = 1; gen_data = 4'b1011;
        #1;
        total_cnt++; if (gen_ready !== 1'b1 || chk_ready !== 1'b0)
            $display("FAIL gen_ready: gr=%b cr=%b, required 1/0", gen_ready, chk_ready);
        else pass_cnt++;
        tick();
        gen_valid = 0;
        total_cnt++; if (res_valid !== 1 || res_src !== 0 || res_data !== 4'b1011 || res_par !== 1 || res_err !== 0)
            $display("FAIL gen_result: valid=%b src=%b data=%b par=%b err=%b, required 1 0 1011 1 0", res_valid, res_src, res_data, res_par, res_err);
        else pass_cnt++;
    endtask

    task automatic test_single_chk();
        idle_inputs();
        chk_valid = 1; chk_data = 4'b0111; chk_par = 0;
        #1;
        total_cnt++; if (chk_ready !== 1'b1 || gen_ready !== 1'b0)
            $display("FAIL chk_ready: cr=%b gr=%b, required 1/0", chk_ready, gen_ready);
        else pass_cnt++;
        tick();
        total_cnt++; if (res_valid !== 1 || res_src !== 1 || res_par !== 0 || res_err !== 1 || err_cnt !== 8'd1 || err_sticky !== 1)
            $display("FAIL chk_err: valid=%b src=%b par=%b err=%b cnt=%0d sticky=%b, required 1 1 0 1 1 1", res_valid, res_src, res_par, res_err, err_cnt, err_sticky);
        else pass_cnt++;
        chk_data = 4'b1001; chk_par = 0;
        tick();
        chk_valid = 0;
        total_cnt++; if (res_err !== 0 || res_data !== 4'b1001 || err_cnt !== 8'd1 || err_sticky !== 1)
            $display("FAIL chk_ok: err=%b data=%b cnt=%0d sticky=%b, required 0 1001 1 1", res_err, res_data, err_cnt, err_sticky);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        logic exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            gen_valid = 1; gen_data = 4'(i + 2);
            chk_valid = 1; chk_data = 4'(i + 9); chk_par = even_par(4'(i + 9));
            #1;
            total_cnt++; if ((gen_ready && chk_ready) || !(gen_ready || chk_ready))
                $display("FAIL tie_onehot[%0d]: gr=%b cr=%b, required exactly one", i, gen_ready, chk_ready);
            else pass_cnt++;
            tick();
            total_cnt++; if (res_valid !== 1'b1 || res_src !== exp_src[i])
                $display("FAIL tie_src[%0d]: valid=%b src=%b, required 1 %b", i, res_valid, res_src, exp_src[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic       s_src, s_par, s_err;
        logic [3:0] s_data;
        s_src = m_src; s_data = m_data; s_par = m_par; s_err = m_err;
        res_ready = 0; gen_valid = 1; gen_data = 4'hE; chk_valid = 1; chk_data = 4'h3; chk_par = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (gen_ready !== 0 || chk_ready !== 0)
                $display("FAIL bp_ready[%0d]: gr=%b cr=%b, required 0 0", i, gen_ready, chk_ready);
            else pass_cnt++;
            tick();
            total_cnt++; if (res_valid !== 1 || res_src !== s_src || res_data !== s_data || res_par !== s_par || res_err !== s_err)
                $display("FAIL bp_hold[%0d]: valid=%b src=%b data=%h par=%b err=%b, required 1 %b %h %b %b",
                         i, res_valid, res_src, res_data, res_par, res_err, s_src, s_data, s_par, s_err);
            else pass_cnt++;
        end
        res_ready = 1;
        #1;
        total_cnt++; if (gen_ready !== 1 || chk_ready !== 0)
            $display("FAIL bp_release: gr=%b cr=%b, required 1 0", gen_ready, chk_ready);
        else pass_cnt++;
        tick();
        total_cnt++; if (res_valid !== 1 || res_src !== 0 || res_data !== 4'hE || res_par !== 1)
            $display("FAIL bp_next: valid=%b src=%b data=%h par=%b, required 1 0 e 1", res_valid, res_src, res_data, res_par);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
        chk_valid = 1; chk_data = 4'b0111; chk_par = 0;
        repeat (5) tick();
        total_cnt++; if (err_cnt2 !== 2'd3 || err_sticky2 !== 1 || err_cnt !== 8'd5)
            $display("FAIL sat_cnt: cnt2=%0d sticky2=%b cnt8=%0d, required 3 1 5", err_cnt2, err_sticky2, err_cnt);
        else pass_cnt++;
        clr = 1;
        tick();
        clr = 0; chk_valid = 0;
        total_cnt++; if (err_cnt2 !== 2'd0 || err_sticky2 !== 0 || err_cnt !== 8'd0 || err_sticky !== 0 || res_err !== 1)
            $display("FAIL clr_wins: cnt2=%0d sticky2=%b cnt8=%0d sticky=%b res_err=%b, required 0 0 0 0 1",
                     err_cnt2, err_sticky2, err_cnt, err_sticky, res_err);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic eg, ec;
        int   bad = 0;
        for (int i = 0; i < 400; i++) begin
            gen_valid = ($urandom_range(0, 99) < 60);
            gen_data  = 4'($urandom);
            chk_valid = ($urandom_range(0, 99) < 60);
            chk_data  = 4'($urandom);
            chk_par   = 1'($urandom);
            res_ready = ($urandom_range(0, 99) < 70);
            clr       = ($urandom_range(0, 99) < 4);
            #1;
            model_ready(eg, ec);
            total_cnt++; if (gen_ready !== eg || chk_ready !== ec || gen_ready2 !== eg || chk_ready2 !== ec) begin
                $display("FAIL rnd_ready[%0d]: gr=%b cr=%b, required %b %b", i, gen_ready, chk_ready, eg, ec);
                bad++;
            end else pass_cnt++;
            tick();
            total_cnt++; if (res_valid !== m_valid || (m_valid && (res_src !== m_src || res_data !== m_data ||
                             res_par !== m_par || res_err !== m_err))) begin
                $display("FAIL rnd_res[%0d]: v=%b s=%b d=%h p=%b e=%b, required %b %b %h %b %b",
                         i, res_valid, res_src, res_data, res_par, res_err, m_valid, m_src, m_data, m_par, m_err);
                bad++;
            end else pass_cnt++;
            total_cnt++; if (err_cnt !== 8'(m_cnt8) || err_cnt2 !== 2'(m_cnt2) || err_sticky !== m_sticky || err_sticky2 !== m_sticky) begin
                $display("FAIL rnd_status[%0d]: cnt8=%0d cnt2=%0d sticky=%b, required %0d %0d %b",
                         i, err_cnt, err_cnt2, err_sticky, m_cnt8, m_cnt2, m_sticky);
                bad++;
            end else pass_cnt++;
            if (bad > 10) break;
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        chk_valid = 1; chk_data = 4'b0001; chk_par = 0;
        tick();
        res_ready = 0; chk_valid = 0;
        tick();
        total_cnt++; if (res_valid !== 1 || err_sticky !== 1)
            $display("FAIL pre_reset: valid=%b sticky=%b, required 1 1", res_valid, err_sticky);
        else pass_cnt++;
        #2;
        rst_n = 0;
        #1;
        total_cnt++; if (res_valid !== 0 || err_cnt !== 8'd0 || err_sticky !== 0 || res_valid2 !== 0 || err_cnt2 !== 2'd0)
            $display("FAIL async_reset: valid=%b cnt=%0d sticky=%b, required 0 0 0", res_valid, err_cnt, err_sticky);
        else pass_cnt++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        res_ready = 1; gen_valid = 1; gen_data = 4'h5; chk_valid = 1; chk_data = 4'h6; chk_par = 0;
        #1;
        total_cnt++; if (gen_ready !== 1 || chk_ready !== 0)
            $display("FAIL reset_tie: gr=%b cr=%b, required 1 0", gen_ready, chk_ready);
        else pass_cnt++;
        tick();
        total_cnt++; if (res_valid !== 1 || res_src !== 0 || res_data !== 4'h5 || res_par !== 0)
            $display("FAIL reset_tie_res: valid=%b src=%b data=%h par=%b, required 1 0 5 0", res_valid, res_src, res_data, res_par);
        else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_gen();
        test_single_chk();
        test_tie();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
